bram_tdp_param: RTL and testbench
=================================

BRAM_TDP_PARAM -- requirements
Module: bram_tdp_param

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_W, 32, word width
- ADDR_W, 4, address bits, legal range 1 and up
- DEPTH, 1<<ADDR_W, entries
- BYTE_W, 8, byte-lane width
- RD_LAT, 2, read latency, legal values 1 or 2
- WR_MODE, 0, write-port read behaviour: 0 = no-change, 1 = read-first, 2 = write-first
- CLR_ON_RST, 1, clear memory after reset
REQ-002 Elaboration SHALL fail unless DATA_W % BYTE_W == 0, RD_LAT is in {1,2} and WR_MODE is in {0,1,2}.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock
- rstn_i, in, 1, asynchronous active-low reset
- a_req_i, in, 1, port A access request
- a_we_i, in, 1, port A write
- a_be_i, in, NB=DATA_W/BYTE_W, port A byte enables
- a_addr_i, in, ADDR_W, port A address
- a_din_i, in, DATA_W, port A write data
- a_gnt_o, out, 1, port A request accepted this cycle
- a_rvalid_o, out, 1, port A read data valid
- a_rdata_o, out, DATA_W, port A read data
- b_* ports, identical to the port A set
- init_busy_o, out, 1, clear in progress
- coll_o, out, 1, same-address collision pulse
REQ-004 The block SHALL use one clock (clk_i); reset (rstn_i) SHALL be asynchronous and active-low.

Function
REQ-005 A request SHALL be accepted when x_req_i && x_gnt_o; x_gnt_o SHALL equal !init_busy_o, combinationally.
REQ-006 An accepted write SHALL update only the byte lanes whose x_be_i bit is 1; other lanes keep their stored value.
REQ-007 An accepted read SHALL assert x_rvalid_o for one cycle exactly RD_LAT cycles after acceptance, with x_rdata_o = the word stored before any same-cycle write.
REQ-008 Write response by WR_MODE:
- 0: no rvalid, and rdata holds its last value
- 1: rvalid after RD_LAT with the pre-write word
- 2: rvalid after RD_LAT with the post-merge word
REQ-009 x_rdata_o SHALL hold its value whenever x_rvalid_o is low.
REQ-010 Back-to-back accepted requests SHALL be fully pipelined, one per cycle per port, with no bubbles.
REQ-011 A collision is both ports accepted in the same cycle, same address, at least one of them a write. On a collision coll_o SHALL pulse high for one cycle.
REQ-012 On a write/write collision, port A's write SHALL be committed and port B's write dropped entirely; port B's response follows WR_MODE as if its write had been committed.
REQ-013 On a write/read collision, the reading port SHALL return the pre-write word.
REQ-014 Clear FSM states are RESET, CLEAR and READY.
- RESET to CLEAR on the first clock after rstn_i deasserts, if CLR_ON_RST=1; otherwise RESET to READY.
- In CLEAR, port A zeroes even addresses and port B zeroes odd addresses, two per cycle, for DEPTH/2 cycles.
- CLEAR to READY after the address-counter wrap (last pair DEPTH-2, DEPTH-1).
REQ-015 init_busy_o SHALL be high in the RESET and CLEAR states.
REQ-016 Requests during CLEAR SHALL be ignored, because no grant is given.

Reset
REQ-017 While rstn_i is low, the following SHALL hold:
- FSM = RESET
- init_busy_o = 1
- x_rvalid_o = 0
- x_rdata_o = 0
- coll_o = 0
- read pipelines flushed
REQ-018 Reset SHALL NOT alter memory contents unless CLR_ON_RST=1, in which case the post-reset CLEAR sequence zeroes them.
REQ-019 Reset asserted mid-CLEAR or mid-read SHALL abort immediately. In-flight reads SHALL produce no rvalid, and CLEAR restarts from address 0.

Structure
REQ-020 Package bram_pkg SHALL hold:
- the WR_MODE constants (WM_NOCHANGE, WM_RDFIRST, WM_WRFIRST)
- the clear-FSM state enum
REQ-021 The sub-module bram_rd_pipe SHALL implement the per-port RD_LAT valid/data pipeline with hold behaviour, instantiated once per port.
REQ-022 The storage array SHALL be a single inferred true-dual-port RAM with byte-write enables. Collision arbitration SHALL be logic outside the array.

Verification
REQ-023 Clear: DATA_W=32, ADDR_W=4, CLR_ON_RST=1.
- Release reset -> init_busy_o high for exactly 8 cycles.
- Then reads of all 16 addresses return 0x00000000.
REQ-024 Byte write:
- A writes 0xAABBCCDD, be=4'b1111, to address 3.
- Then B writes 0x11223344, be=4'b0101, to address 3.
- Then A reads address 3 -> rdata 0xAA22CC44, with rvalid exactly RD_LAT=2 cycles after acceptance.
REQ-025 WR_MODE=1: address 5 holds 0x1; A writes 0x2 to address 5 -> a_rvalid_o returns 0x1. Same test with WR_MODE=2 -> returns 0x2. With WR_MODE=0 -> no rvalid, and rdata unchanged.
REQ-026 Collision, same cycle, address 7:
- A writes 0x5, B writes 0x9 -> coll_o pulses once.
- A subsequent read of address 7 returns 0x5.
- With A writing 0x6 and B reading address 7 in the same cycle -> B returns 0x5.
REQ-027 Throughput: 16 consecutive A reads interleaved with B writes to disjoint addresses -> 16 A rvalids on consecutive cycles, all data correct.
REQ-028 Reset abort:
- Assert rstn_i one cycle after issuing a read -> no rvalid appears.
- Assert rstn_i at CLEAR cycle 4 -> a full 8-cycle CLEAR follows release.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants and types for the parameterised true-dual-port block RAM.
package bram_pkg;

   localparam int unsigned WM_NOCHANGE = 32'd0;
   localparam int unsigned WM_RDFIRST  = 32'd1;
   localparam int unsigned WM_WRFIRST  = 32'd2;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } clr_state_e;

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read-response pipeline: valid emerges RD_LAT cycles after entry and
// the output word holds its last value whenever valid is low.
module bram_rd_pipe
   import bram_pkg::*;
#(
   parameter int unsigned DATA_W = 32'd32,
   parameter int unsigned RD_LAT = 32'd2
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [DATA_W-1:0] dat_q [RD_LAT];
   logic [DATA_W-1:0] dat_d [RD_LAT];

   // Stage shift; a data stage only loads behind a valid, so the tail holds.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      vld_d[0] = valid_i;
      if (valid_i) begin
         dat_d[0] = data_i;
      end else begin
         dat_d[0] = dat_q[0];
      end
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         if (vld_q[i-1]) begin
            dat_d[i] = dat_q[i-1];
         end else begin
            dat_d[i] = dat_q[i];
         end
      end
   end

   // Pipeline registers, flushed by reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign valid_o = vld_q[RD_LAT-1];
   assign data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/bram_tdp_param.sv
// True-dual-port byte-writable RAM with per-port read pipelines, same-address
// collision arbitration (port A wins) and an optional post-reset clear sequence.
module bram_tdp_param
   import bram_pkg::*;
#(
   parameter int unsigned DATA_W     = 32'd32,
   parameter int unsigned ADDR_W     = 32'd4,
   parameter int unsigned DEPTH      = 32'd1 << ADDR_W,
   parameter int unsigned BYTE_W     = 32'd8,
   parameter int unsigned RD_LAT     = 32'd2,
   parameter int unsigned WR_MODE    = 32'd0,
   parameter int unsigned CLR_ON_RST = 32'd1
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       a_req_i,
   input  logic                       a_we_i,
   input  logic [DATA_W/BYTE_W-1:0]   a_be_i,
   input  logic [ADDR_W-1:0]          a_addr_i,
   input  logic [DATA_W-1:0]          a_din_i,
   output logic                       a_gnt_o,
   output logic                       a_rvalid_o,
   output logic [DATA_W-1:0]          a_rdata_o,
   input  logic                       b_req_i,
   input  logic                       b_we_i,
   input  logic [DATA_W/BYTE_W-1:0]   b_be_i,
   input  logic [ADDR_W-1:0]          b_addr_i,
   input  logic [DATA_W-1:0]          b_din_i,
   output logic                       b_gnt_o,
   output logic                       b_rvalid_o,
   output logic [DATA_W-1:0]          b_rdata_o,
   output logic                       init_busy_o,
   output logic                       coll_o
);

   localparam int unsigned NB = DATA_W / BYTE_W;

   if (((DATA_W % BYTE_W) != 32'd0) || (RD_LAT < 32'd1) || (RD_LAT > 32'd2) ||
       (WR_MODE > 32'd2) || (ADDR_W < 32'd1) || (DEPTH < 32'd2)) begin : g_bad_params
      $error("bram_tdp_param: illegal parameter combination");
   end

   function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [NB-1:0]     be);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int l = 0; l < NB; l++) begin
         if (be[l]) begin
            res[l*BYTE_W +: BYTE_W] = new_w[l*BYTE_W +: BYTE_W];
         end
      end
      return res;
   endfunction

   // Write-port response word: write-first returns the merged word, else the stored one.
   function automatic logic [DATA_W-1:0] rsp_word(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] din,
                                                  input logic [NB-1:0]     be,
                                                  input logic              we);
      if (we && (WR_MODE == WM_WRFIRST)) begin
         return be_merge(old_w, din, be);
      end else begin
         return old_w;
      end
   endfunction

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              coll_q, coll_d;
   logic              busy_s, clearing_s;
   logic              a_acc_s, b_acc_s, ww_coll_s;
   logic [DATA_W-1:0] a_old_s, b_old_s;
   logic              a_wen_s, b_wen_s;
   logic [ADDR_W-1:0] a_waddr_s, b_waddr_s;
   logic [DATA_W-1:0] a_wdata_s, b_wdata_s;
   logic [NB-1:0]     a_wbe_s, b_wbe_s;
   logic              a_rsp_vld_s, b_rsp_vld_s;
   logic [DATA_W-1:0] a_rsp_dat_s, b_rsp_dat_s;
   logic [DATA_W-1:0] mem_q [DEPTH];

   assign busy_s      = (state_q != ST_READY);
   assign clearing_s  = (state_q == ST_CLEAR);
   assign init_busy_o = busy_s;
   assign a_gnt_o     = !busy_s;
   assign b_gnt_o     = !busy_s;
   assign a_acc_s     = a_req_i && !busy_s;
   assign b_acc_s     = b_req_i && !busy_s;
   assign ww_coll_s   = a_acc_s && b_acc_s && a_we_i && b_we_i && (a_addr_i == b_addr_i);

   // Clear sequencer: one even/odd address pair per cycle, done after the last pair.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      coll_d     = a_acc_s && b_acc_s && (a_addr_i == b_addr_i) && (a_we_i || b_we_i);
      case (state_q)
         ST_RESET: begin
            clr_addr_d = '0;
            if (CLR_ON_RST != 32'd0) begin
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_READY;
            end
         end
         ST_CLEAR: begin
            if (clr_addr_q == ADDR_W'(DEPTH - 32'd2)) begin
               state_d    = ST_READY;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_W'(2);
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d    = ST_RESET;
            clr_addr_d = '0;
         end
      endcase
   end

   // Control registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_RESET;
         clr_addr_q <= '0;
         coll_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         coll_q     <= coll_d;
      end
   end

   assign coll_o = coll_q;

   // Array write-port steering; B's write is dropped when it loses to A.
   always_comb begin
      if (clearing_s) begin
         a_wen_s   = 1'b1;
         a_waddr_s = clr_addr_q;
         a_wdata_s = '0;
         a_wbe_s   = '1;
         b_wen_s   = 1'b1;
         b_waddr_s = clr_addr_q | ADDR_W'(1);
         b_wdata_s = '0;
         b_wbe_s   = '1;
      end else begin
         a_wen_s   = a_acc_s && a_we_i;
         a_waddr_s = a_addr_i;
         a_wdata_s = a_din_i;
         a_wbe_s   = a_be_i;
         b_wen_s   = b_acc_s && b_we_i && !ww_coll_s;
         b_waddr_s = b_addr_i;
         b_wdata_s = b_din_i;
         b_wbe_s   = b_be_i;
      end
   end

   // Storage array: byte-enabled dual write, contents survive reset.
   always_ff @(posedge clk_i) begin
      for (int l = 0; l < NB; l++) begin
         if (a_wen_s && a_wbe_s[l]) begin
            mem_q[a_waddr_s][l*BYTE_W +: BYTE_W] <= a_wdata_s[l*BYTE_W +: BYTE_W];
         end
         if (b_wen_s && b_wbe_s[l]) begin
            mem_q[b_waddr_s][l*BYTE_W +: BYTE_W] <= b_wdata_s[l*BYTE_W +: BYTE_W];
         end
      end
   end

   assign a_old_s     = mem_q[a_addr_i];
   assign b_old_s     = mem_q[b_addr_i];
   assign a_rsp_vld_s = a_acc_s && (!a_we_i || (WR_MODE != WM_NOCHANGE));
   assign b_rsp_vld_s = b_acc_s && (!b_we_i || (WR_MODE != WM_NOCHANGE));
   assign a_rsp_dat_s = rsp_word(a_old_s, a_din_i, a_be_i, a_we_i);
   assign b_rsp_dat_s = rsp_word(b_old_s, b_din_i, b_be_i, b_we_i);

   bram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe_a (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .valid_i (a_rsp_vld_s),
      .data_i  (a_rsp_dat_s),
      .valid_o (a_rvalid_o),
      .data_o  (a_rdata_o)
   );

   bram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe_b (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .valid_i (b_rsp_vld_s),
      .data_i  (b_rsp_dat_s),
      .valid_o (b_rvalid_o),
      .data_o  (b_rdata_o)
   );

endmodule

// File: tb/tb_bram_tdp_param.sv
// Self-checking bench: three instances (one per WR_MODE) driven in lockstep and
// compared every cycle against a word-level memory/response model.
module tb_bram_tdp_param;

   localparam int NM     = 3;
   localparam int DEPTH  = 16;
   localparam int RD_LAT = 2;

   typedef struct packed {
      int          due;
      logic [31:0] data;
   } rsp_t;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic        a_req, a_we, b_req, b_we;
   logic [3:0]  a_be, b_be, a_addr, b_addr;
   logic [31:0] a_din, b_din;
   logic        a_gnt [NM];
   logic        b_gnt [NM];
   logic        a_rvalid [NM];
   logic        b_rvalid [NM];
   logic        busy [NM];
   logic        coll [NM];
   logic [31:0] a_rdata [NM];
   logic [31:0] b_rdata [NM];

   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          busy_until = 0;
   logic [31:0] exp_mem [DEPTH];
   logic [31:0] last [6];
   rsp_t        rq [6][$];
   bit          exp_coll = 1'b0;

   always #5 clk = ~clk;

   for (genvar m = 0; m < NM; m++) begin : g_dut
      bram_tdp_param #(
         .DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RD_LAT(RD_LAT), .WR_MODE(m), .CLR_ON_RST(1)
      ) u_dut (
         .clk_i(clk), .rstn_i(rstn),
         .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_din_i(a_din),
         .a_gnt_o(a_gnt[m]), .a_rvalid_o(a_rvalid[m]), .a_rdata_o(a_rdata[m]),
         .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_din_i(b_din),
         .b_gnt_o(b_gnt[m]), .b_rvalid_o(b_rvalid[m]), .b_rdata_o(b_rdata[m]),
         .init_busy_o(busy[m]), .coll_o(coll[m])
      );
   end

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = n[l*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h cycle=%0d", tag, obs, exp, cycle);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cycle);
      end
   endtask

   task automatic set_a(input logic req, input logic we, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] din);
      a_req = req; a_we = we; a_be = be; a_addr = addr; a_din = din;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] din);
      b_req = req; b_we = we; b_be = be; b_addr = addr; b_din = din;
   endtask

   task automatic idle();
      set_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      set_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
   endtask

   // Reference behaviour of one clock edge, applied to the inputs now on the pins.
   task automatic model_edge();
      bit          busy_now, aa, ba;
      logic [31:0] old_a, old_b;
      busy_now = !rstn || (cycle < busy_until);
      aa = rstn && !busy_now && a_req;
      ba = rstn && !busy_now && b_req;
      old_a = exp_mem[a_addr];
      old_b = exp_mem[b_addr];
      for (int m = 0; m < NM; m++) begin
         if (aa && (!a_we || m != 0))
            rq[m*2].push_back('{cycle + RD_LAT, (a_we && m == 2) ? merge(old_a, a_din, a_be) : old_a});
         if (ba && (!b_we || m != 0))
            rq[m*2+1].push_back('{cycle + RD_LAT, (b_we && m == 2) ? merge(old_b, b_din, b_be) : old_b});
      end
      exp_coll = aa && ba && (a_addr == b_addr) && (a_we || b_we);
      if (aa && a_we) exp_mem[a_addr] = merge(exp_mem[a_addr], a_din, a_be);
      if (ba && b_we && !(aa && a_we && a_addr == b_addr))
         exp_mem[b_addr] = merge(exp_mem[b_addr], b_din, b_be);
   endtask

   task automatic check_outputs();
      bit exp_busy, ev;
      int q;
      exp_busy = !rstn || (cycle < busy_until);
      for (int m = 0; m < NM; m++) begin
         chk1($sformatf("m%0d_busy", m), busy[m], exp_busy);
         chk1($sformatf("m%0d_a_gnt", m), a_gnt[m], !exp_busy);
         chk1($sformatf("m%0d_b_gnt", m), b_gnt[m], !exp_busy);
         chk1($sformatf("m%0d_coll", m), coll[m], exp_coll);
         for (int p = 0; p < 2; p++) begin
            q  = m*2 + p;
            ev = 1'b0;
            if (rq[q].size() > 0 && rq[q][0].due == cycle) begin
               ev = 1'b1;
               last[q] = rq[q][0].data;
               void'(rq[q].pop_front());
            end
            chk1($sformatf("m%0d_%s_rvalid", m, p ? "b" : "a"), p ? b_rvalid[m] : a_rvalid[m], ev);
            chk($sformatf("m%0d_%s_rdata", m, p ? "b" : "a"), p ? b_rdata[m] : a_rdata[m], last[q]);
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cycle++;
      check_outputs();
   endtask

   task automatic do_reset(input int hold);
      rstn = 1'b0;
      idle();
      for (int q = 0; q < 6; q++) begin
         rq[q].delete();
         last[q] = 32'h0;
      end
      exp_coll = 1'b0;
      #1;
      check_outputs();
      repeat (hold) tick();
      rstn = 1'b1;
      busy_until = cycle + DEPTH/2 + 1;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
   endtask

   task automatic count_clear(input string tag);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (busy[0]) n++;
         else done = 1'b1;
      end
      chk(tag, 32'(n), 32'd8);
   endtask

   initial begin
      int          zc, nv, first_v, last_v;
      logic [31:0] r, s;
      idle();
      #2;
      do_reset(3);
      count_clear("clear_len");

      zc = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         if (i < DEPTH) set_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
         else idle();
         tick();
         if (a_rvalid[0] && a_rdata[0] === 32'h0) zc++;
      end
      chk("clear_zero_reads", 32'(zc), 32'd16);

      set_a(1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD); tick(); idle();
      set_b(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344); tick(); idle();
      set_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0); tick(); idle();
      chk1("byte_rvalid_lat1", a_rvalid[0], 1'b0);
      tick();
      chk1("byte_rvalid_lat2", a_rvalid[0], 1'b1);
      chk("byte_merge", a_rdata[0], 32'hAA22CC44);
      tick();
      chk1("byte_rvalid_lat3", a_rvalid[0], 1'b0);

      set_a(1'b1, 1'b1, 4'hF, 4'd5, 32'h1); tick(); idle(); tick(); tick();
      set_a(1'b1, 1'b1, 4'hF, 4'd5, 32'h2); tick(); idle(); tick();
      chk1("wm1_rvalid", a_rvalid[1], 1'b1);
      chk("wm1_rdata", a_rdata[1], 32'h1);
      chk1("wm2_rvalid", a_rvalid[2], 1'b1);
      chk("wm2_rdata", a_rdata[2], 32'h2);
      chk1("wm0_rvalid", a_rvalid[0], 1'b0);
      chk("wm0_rdata_hold", a_rdata[0], 32'hAA22CC44);
      tick();

      set_a(1'b1, 1'b1, 4'hF, 4'd7, 32'h5);
      set_b(1'b1, 1'b1, 4'hF, 4'd7, 32'h9);
      tick(); idle();
      chk1("ww_coll_pulse", coll[0], 1'b1);
      tick();
      chk1("ww_coll_end", coll[0], 1'b0);
      set_a(1'b1, 1'b0, 4'h0, 4'd7, 32'h0); tick(); idle(); tick();
      chk("ww_a_wins", a_rdata[0], 32'h5);
      set_a(1'b1, 1'b1, 4'hF, 4'd7, 32'h6);
      set_b(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
      tick(); idle();
      chk1("wr_coll_pulse", coll[0], 1'b1);
      tick();
      chk1("wr_b_rvalid", b_rvalid[0], 1'b1);
      chk("wr_b_prewrite", b_rdata[0], 32'h5);
      tick();

      nv = 0; first_v = -1; last_v = -1;
      for (int i = 0; i < DEPTH + 4; i++) begin
         if (i < DEPTH) begin
            set_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            set_b(1'b1, 1'b1, 4'($urandom_range(1, 15)), 4'((i + 8) % DEPTH), $urandom);
         end else begin
            idle();
         end
         tick();
         if (a_rvalid[0]) begin
            nv++;
            if (first_v < 0) first_v = cycle;
            last_v = cycle;
         end
      end
      chk("tput_count", 32'(nv), 32'd16);
      chk("tput_span", 32'(last_v - first_v), 32'd15);

      for (int i = 0; i < 300; i++) begin
         r = $urandom;
         s = $urandom;
         set_a(r[0], r[1], r[5:2], r[8] ? r[12:9] : {2'b00, r[7:6]}, $urandom);
         set_b(s[0], s[1], s[5:2], s[8] ? s[12:9] : {2'b00, s[7:6]}, $urandom);
         tick();
      end
      idle(); tick(); tick();

      set_a(1'b1, 1'b0, 4'h0, 4'd2, 32'h0); tick();
      do_reset(2);
      chk1("abort_read_no_rvalid", a_rvalid[0], 1'b0);
      count_clear("clear_len_after_read_abort");

      do_reset(2);
      repeat (4) tick();
      do_reset(2);
      count_clear("clear_len_after_clear_abort");

      for (int i = 0; i < 6; i++) begin
         if (i < 4) set_a(1'b1, 1'b0, 4'h0, 4'(i * 5), 32'h0);
         else idle();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
